// File: rtl/ff_compare_monitor_pkg.sv
// Shared types and default constants for the JK flip-flop compare monitor.
package ff_mon_pkg;

  typedef enum logic [1:0] {
    AGREE   = 2'd0,
    DIVERGE = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam int COUNT_W_DEF        = 8;
  localparam int MISMATCH_LIMIT_DEF = 3;

endpackage

// File: rtl/ff_compare_monitor_if.sv
// Bus between the monitor and its environment: sampled flip-flop outputs,
// clear control, and the monitor's counters and status.
interface ff_compare_monitor_if
  import ff_mon_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
);

  logic               clear;
  logic               q_sync;
  logic               q_async;
  logic [COUNT_W-1:0] toggles_sync;
  logic [COUNT_W-1:0] toggles_async;
  logic               mismatch;
  logic               fault;
  state_t             state;

  modport master (
    output clear, q_sync, q_async,
    input  toggles_sync, toggles_async, mismatch, fault, state
  );

  modport slave (
    input  clear, q_sync, q_async,
    output toggles_sync, toggles_async, mismatch, fault, state
  );

endinterface

// File: rtl/ff_compare_monitor_toggle_counter.sv
// Saturating transition counter for one sampled signal, with its own
// previous-value register and synchronous clear.
module toggle_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_d,
  output logic [COUNT_W-1:0] o_count
);

  logic               r_prev;
  logic [COUNT_W-1:0] r_count;
  logic               w_edge;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

  assign w_edge = i_d ^ r_prev;

  // The previous value keeps tracking during clear so the cycle after a
  // clear compares against the true last sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_prev <= i_d;
      if (i_clear)
        r_count <= '0;
      else if (w_edge)
        r_count <= sat_inc(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ff_compare_monitor.sv
// Compares the outputs of a sync-reset and an async-reset JK flip-flop.
// Build option FF_MON_STICKY_EN: FAULT is held until clear or reset.
module ff_compare_monitor
  import ff_mon_pkg::*;
#(
  parameter int COUNT_W        = COUNT_W_DEF,
  parameter int MISMATCH_LIMIT = MISMATCH_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  ff_compare_monitor_if.slave  bus
);

  localparam logic [COUNT_W-1:0] LIMIT_C  = COUNT_W'(MISMATCH_LIMIT);
  localparam logic [COUNT_W-1:0] LIMIT_M1 = COUNT_W'(MISMATCH_LIMIT - 1);

  logic               w_diff;
  logic [COUNT_W-1:0] w_cnt_sync;
  logic [COUNT_W-1:0] w_cnt_async;
  logic               r_mismatch;
  logic               r_fault;
  logic [COUNT_W-1:0] r_run;
  state_t             r_state;

  assign w_diff = bus.q_sync ^ bus.q_async;

  toggle_counter #(.COUNT_W(COUNT_W)) u_tc_sync (
    .clk     (clk),
    .reset   (reset),
    .i_clear (bus.clear),
    .i_d     (bus.q_sync),
    .o_count (w_cnt_sync)
  );

  toggle_counter #(.COUNT_W(COUNT_W)) u_tc_async (
    .clk     (clk),
    .reset   (reset),
    .i_clear (bus.clear),
    .i_d     (bus.q_async),
    .o_count (w_cnt_async)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_mismatch <= 1'b0;
    else
      r_mismatch <= w_diff;
  end

  // Run counter only advances while below LIMIT-1, so it tops out at LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= AGREE;
      r_run   <= '0;
      r_fault <= 1'b0;
    end else if (bus.clear) begin
      r_state <= AGREE;
      r_run   <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        AGREE: begin
          if (w_diff) begin
            r_run <= COUNT_W'(1);
            if (MISMATCH_LIMIT == 1) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= DIVERGE;
              r_fault <= 1'b0;
            end
          end else begin
            r_run   <= '0;
            r_fault <= 1'b0;
          end
        end
        DIVERGE: begin
          if (!w_diff) begin
            r_state <= AGREE;
            r_run   <= '0;
            r_fault <= 1'b0;
          end else if (r_run >= LIMIT_M1) begin
            r_state <= FAULT;
            r_run   <= LIMIT_C;
            r_fault <= 1'b1;
          end else begin
            r_run   <= r_run + COUNT_W'(1);
            r_fault <= 1'b0;
          end
        end
        FAULT: begin
`ifdef FF_MON_STICKY_EN
          r_state <= FAULT;
          r_fault <= 1'b1;
`else
          if (!w_diff) begin
            r_state <= AGREE;
            r_run   <= '0;
            r_fault <= 1'b0;
          end else begin
            r_fault <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= AGREE;
          r_run   <= '0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign bus.toggles_sync  = w_cnt_sync;
  assign bus.toggles_async = w_cnt_async;
  assign bus.mismatch      = r_mismatch;
  assign bus.fault         = r_fault;
  assign bus.state         = r_state;

endmodule
